pwm_cfg_ctrl: RTL and testbench

Configuration and sequencing controller for the PWM counter. It owns the counter's control inputs: `en`, `count_reset`, `period`, `prescale` and `upnotdown`. It also holds the active compare value used by the PWM comparator. Register-interface writes land in a shadow bank through a valid/ready handshake and are committed glitch-free at a period boundary, or immediately on request. Start/stop sequencing always restarts the counter and prescaler from zero.

---
 rtl/pwm_cfg_ctrl_if.sv | 21 ++
 rtl/pwm_cfg_ctrl.sv | 108 ++++++++++
 tb/tb_pwm_cfg_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_cfg_ctrl_if.sv
// Configuration handshake bundle between a register front-end and pwm_cfg_ctrl.
// A transfer happens on any cycle where cfg_valid and cfg_ready are both high.
interface pwm_cfg_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_prescale;
  logic [15:0] cfg_compare;
  logic        cfg_upnotdown;
  logic        cfg_immediate;

  modport master (
    output cfg_valid, cfg_period, cfg_prescale, cfg_compare, cfg_upnotdown, cfg_immediate,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_prescale, cfg_compare, cfg_upnotdown, cfg_immediate,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_cfg_ctrl.sv
// PWM counter configuration/sequencing controller: shadow/active register banks,
// glitch-free commit at a counter wrap (or on demand), and start/stop sequencing.
module pwm_cfg_ctrl (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  pwm_cfg_ctrl_if.slave      cfg,
  input  logic [15:0]        count_val,
  output logic               en,
  output logic               count_reset,
  output logic [15:0]        period,
  output logic [7:0]         prescale,
  output logic               upnotdown,
  output logic [15:0]        compare,
  output logic               update_done,
  output logic               period_evt,
  output logic               running
);

  typedef enum logic [2:0] {IDLE, START, RUN, PEND, COMMIT, STOP} state_t;

  typedef struct packed {
    logic [15:0] period;
    logic [7:0]  prescale;
    logic [15:0] compare;
    logic        upnotdown;
  } bank_t;

  localparam bank_t BANK_RST = '{period: 16'd0, prescale: 8'd0, compare: 16'd0, upnotdown: 1'b1};

  state_t      state, nxt;
  bank_t       shadow, active, cfg_bank;
  logic        imm_flag, first_run;
  logic [15:0] count_d;
  logic        ready, hs, wrap_raw, wrap, load_direct, commit_shadow;

  assign cfg_bank = '{period:    cfg.cfg_period,
                      prescale:  cfg.cfg_prescale,
                      compare:   cfg.cfg_compare,
                      upnotdown: cfg.cfg_upnotdown};

  assign ready         = (state == IDLE) || (state == RUN);
  assign cfg.cfg_ready = ready;
  assign hs            = cfg.cfg_valid && ready;

  // The first RUN cycle after a clear sees a stale count_d, so it is masked.
  always_comb begin
    wrap_raw = 1'b0;
    if (active.upnotdown) wrap_raw = (count_d == active.period) && (count_val == 16'd0);
    else                  wrap_raw = (count_d == 16'd0) && (count_val == active.period);
    wrap = wrap_raw && (active.period != 16'd0) &&
           (((state == RUN) && !first_run) || (state == PEND));
  end

  assign period_evt = wrap;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start && !stop) nxt = START;
      START:   nxt = RUN;
      RUN:     if (hs) nxt = PEND;
      PEND:    if (wrap || imm_flag || (active.period == 16'd0)) nxt = COMMIT;
      COMMIT:  nxt = RUN;
      STOP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (stop && (state inside {START, RUN, PEND, COMMIT})) nxt = STOP;
  end

  // Leaving PEND, whether to COMMIT or to STOP, always commits the shadow.
  assign load_direct   = (state == IDLE) && hs;
  assign commit_shadow = (state == PEND) && ((nxt == COMMIT) || (nxt == STOP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      active      <= BANK_RST;
      imm_flag    <= 1'b0;
      first_run   <= 1'b0;
      count_d     <= 16'd0;
      update_done <= 1'b0;
      en          <= 1'b0;
      count_reset <= 1'b0;
      running     <= 1'b0;
    end else begin
      state   <= nxt;
      count_d <= count_val;
      if (hs) shadow <= cfg_bank;
      if ((state == RUN) && hs) imm_flag <= cfg.cfg_immediate;
      if (load_direct)        active <= cfg_bank;
      else if (commit_shadow) active <= shadow;
      update_done <= load_direct || commit_shadow;
      en          <= nxt inside {RUN, PEND, COMMIT};
      count_reset <= nxt inside {START, COMMIT, STOP};
      running     <= nxt inside {START, RUN, PEND, COMMIT};
      first_run   <= (state == START) || (state == COMMIT);
    end
  end

  assign period    = active.period;
  assign prescale  = active.prescale;
  assign compare   = active.compare;
  assign upnotdown = active.upnotdown;

endmodule

// File: tb/tb_pwm_cfg_ctrl.sv
// Directed bench for pwm_cfg_ctrl with a behavioural PWM counter driving count_val.
module tb_pwm_cfg_ctrl;
  logic        clk, rst, start, stop;
  logic [15:0] count_val;
  logic        en, count_reset, upnotdown, update_done, period_evt, running;
  logic [15:0] period, compare;
  logic [7:0]  prescale;
  int          total, bad;

  pwm_cfg_ctrl_if cif();

  pwm_cfg_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg(cif),
    .count_val(count_val), .en(en), .count_reset(count_reset), .period(period),
    .prescale(prescale), .upnotdown(upnotdown), .compare(compare),
    .update_done(update_done), .period_evt(period_evt), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: clear has priority, then step once per 2^prescale enabled cycles.
  logic [15:0] cnt;
  logic [31:0] pre_cnt;
  assign count_val = cnt;
  always @(posedge clk) begin
    if (rst || count_reset) begin
      cnt <= 16'd0; pre_cnt <= 32'd0;
    end else if (en) begin
      if (pre_cnt == (32'd1 << prescale) - 32'd1) begin
        pre_cnt <= 32'd0;
        if (upnotdown) cnt <= (cnt == period) ? 16'd0 : cnt + 16'd1;
        else           cnt <= (cnt == 16'd0) ? period : cnt - 16'd1;
      end else begin
        pre_cnt <= pre_cnt + 32'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive_cfg(input logic [15:0] p, input logic [7:0] ps, input logic [15:0] c,
                           input logic u, input logic imm);
    cif.cfg_valid = 1'b1; cif.cfg_period = p; cif.cfg_prescale = ps;
    cif.cfg_compare = c; cif.cfg_upnotdown = u; cif.cfg_immediate = imm;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_period = '0; cif.cfg_prescale = '0;
    cif.cfg_compare = '0; cif.cfg_upnotdown = 1'b0; cif.cfg_immediate = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en got=%0h exp=0", en); end
    total++; if (count_reset !== 1'b0) begin bad++; $display("FAIL rst_count_reset got=%0h exp=0", count_reset); end
    total++; if (period !== 16'd0) begin bad++; $display("FAIL rst_period got=%0h exp=0", period); end
    total++; if (prescale !== 8'd0) begin bad++; $display("FAIL rst_prescale got=%0h exp=0", prescale); end
    total++; if (upnotdown !== 1'b1) begin bad++; $display("FAIL rst_upnotdown got=%0h exp=1", upnotdown); end
    total++; if (compare !== 16'd0) begin bad++; $display("FAIL rst_compare got=%0h exp=0", compare); end
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL rst_update_done got=%0h exp=0", update_done); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running got=%0h exp=0", running); end
    total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready got=%0h exp=1", cif.cfg_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_cfg;
    drive_cfg(16'd9, 8'd0, 16'd4, 1'b1, 1'b0);
    total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0h exp=1", cif.cfg_ready); end
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    total++; if (period !== 16'd9) begin bad++; $display("FAIL idle_period got=%0d exp=9", period); end
    total++; if (compare !== 16'd4) begin bad++; $display("FAIL idle_compare got=%0d exp=4", compare); end
    total++; if (update_done !== 1'b1) begin bad++; $display("FAIL idle_update_done got=%0h exp=1", update_done); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL idle_en got=%0h exp=0", en); end
    @(negedge clk);
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL idle_update_done_clr got=%0h exp=0", update_done); end
  endtask

  task automatic test_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (count_reset !== 1'b1) begin bad++; $display("FAIL start_count_reset got=%0h exp=1", count_reset); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL start_en got=%0h exp=0", en); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%0h exp=1", running); end
    @(negedge clk);
    total++; if (en !== 1'b1) begin bad++; $display("FAIL run_en got=%0h exp=1", en); end
    total++; if (count_reset !== 1'b0) begin bad++; $display("FAIL run_count_reset got=%0h exp=0", count_reset); end
    total++; if (count_val !== 16'd0) begin bad++; $display("FAIL run_count0 got=%0d exp=0", count_val); end
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      total++; if (count_val !== 16'(i % 10)) begin bad++; $display("FAIL run_count i=%0d got=%0d exp=%0d", i, count_val, i % 10); end
      total++; if (period_evt !== (i % 10 == 0)) begin bad++; $display("FAIL run_evt i=%0d got=%0h exp=%0h", i, period_evt, (i % 10 == 0)); end
    end
  endtask

  task automatic test_deferred;
    int n;
    n = 0;
    while (count_val !== 16'd3 && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL defer_wait3 got=timeout exp=count3"); end
    drive_cfg(16'd5, 8'd0, 16'd2, 1'b1, 1'b0);
    total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL defer_ready got=%0h exp=1", cif.cfg_ready); end
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    n = 0;
    while (count_reset !== 1'b1 && n < 20) begin
      total++; if (cif.cfg_ready !== 1'b0 || period !== 16'd9) begin bad++; $display("FAIL defer_hold n=%0d got=ready%0h/period%0d exp=ready0/period9", n, cif.cfg_ready, period); end
      @(negedge clk); n++;
    end
    total++; if (n !== 7) begin bad++; $display("FAIL defer_latency got=%0d exp=7", n); end
    total++; if (period !== 16'd5) begin bad++; $display("FAIL defer_period got=%0d exp=5", period); end
    total++; if (compare !== 16'd2) begin bad++; $display("FAIL defer_compare got=%0d exp=2", compare); end
    total++; if (update_done !== 1'b1) begin bad++; $display("FAIL defer_update_done got=%0h exp=1", update_done); end
    total++; if (en !== 1'b1) begin bad++; $display("FAIL defer_en got=%0h exp=1", en); end
    total++; if (cif.cfg_ready !== 1'b0) begin bad++; $display("FAIL defer_commit_ready got=%0h exp=0", cif.cfg_ready); end
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      total++; if (count_val !== 16'(i)) begin bad++; $display("FAIL defer_count i=%0d got=%0d exp=%0d", i, count_val, i); end
      total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL defer_run_ready i=%0d got=%0h exp=1", i, cif.cfg_ready); end
    end
    @(negedge clk);
    total++; if (period_evt !== 1'b1 || count_val !== 16'd0) begin bad++; $display("FAIL defer_wrap got=evt%0h/cnt%0d exp=evt1/cnt0", period_evt, count_val); end
  endtask

  task automatic test_immediate;
    drive_cfg(16'd5, 8'd0, 16'd3, 1'b0, 1'b1);
    total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL imm_ready got=%0h exp=1", cif.cfg_ready); end
    @(negedge clk);
    cif.cfg_valid = 1'b0; cif.cfg_immediate = 1'b0;
    total++; if (count_reset !== 1'b0 || upnotdown !== 1'b1) begin bad++; $display("FAIL imm_pend got=crst%0h/dir%0h exp=crst0/dir1", count_reset, upnotdown); end
    @(negedge clk);
    total++; if (count_reset !== 1'b1) begin bad++; $display("FAIL imm_commit_crst got=%0h exp=1", count_reset); end
    total++; if (upnotdown !== 1'b0 || compare !== 16'd3) begin bad++; $display("FAIL imm_commit_bank got=dir%0h/cmp%0d exp=dir0/cmp3", upnotdown, compare); end
    total++; if (update_done !== 1'b1) begin bad++; $display("FAIL imm_update_done got=%0h exp=1", update_done); end
    @(negedge clk);
    total++; if (count_val !== 16'd0 || update_done !== 1'b0) begin bad++; $display("FAIL imm_clear got=cnt%0d/ud%0h exp=cnt0/ud0", count_val, update_done); end
    @(negedge clk);
    total++; if (count_val !== 16'd5 || period_evt !== 1'b1) begin bad++; $display("FAIL imm_down5 got=cnt%0d/evt%0h exp=cnt5/evt1", count_val, period_evt); end
    @(negedge clk);
    total++; if (count_val !== 16'd4 || period_evt !== 1'b0) begin bad++; $display("FAIL imm_down4 got=cnt%0d/evt%0h exp=cnt4/evt0", count_val, period_evt); end
  endtask

  task automatic test_zero_period;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if (en !== 1'b0 || count_reset !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL zp_stop got=en%0h/crst%0h/run%0h exp=en0/crst1/run0", en, count_reset, running); end
    @(negedge clk);
    total++; if (count_reset !== 1'b0 || cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL zp_idle got=crst%0h/rdy%0h exp=crst0/rdy1", count_reset, cif.cfg_ready); end
    drive_cfg(16'd0, 8'd0, 16'd0, 1'b1, 1'b0);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (en !== 1'b1 || period !== 16'd0) begin bad++; $display("FAIL zp_run got=en%0h/per%0d exp=en1/per0", en, period); end
    drive_cfg(16'd7, 8'd0, 16'd1, 1'b1, 1'b0);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    total++; if (count_reset !== 1'b0 || period !== 16'd0) begin bad++; $display("FAIL zp_pend got=crst%0h/per%0d exp=crst0/per0", count_reset, period); end
    @(negedge clk);
    total++; if (count_reset !== 1'b1 || period !== 16'd7 || update_done !== 1'b1) begin bad++; $display("FAIL zp_commit got=crst%0h/per%0d/ud%0h exp=crst1/per7/ud1", count_reset, period, update_done); end
  endtask

  task automatic test_stop_pend;
    @(negedge clk);
    total++; if (cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL sp_ready got=%0h exp=1", cif.cfg_ready); end
    drive_cfg(16'd3, 8'd0, 16'd2, 1'b1, 1'b0);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    total++; if (cif.cfg_ready !== 1'b0 || period !== 16'd7) begin bad++; $display("FAIL sp_pend got=rdy%0h/per%0d exp=rdy0/per7", cif.cfg_ready, period); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++; if (period !== 16'd3 || compare !== 16'd2) begin bad++; $display("FAIL sp_bank got=per%0d/cmp%0d exp=per3/cmp2", period, compare); end
    total++; if (update_done !== 1'b1) begin bad++; $display("FAIL sp_update_done got=%0h exp=1", update_done); end
    total++; if (en !== 1'b0 || count_reset !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL sp_stop got=en%0h/crst%0h/run%0h exp=en0/crst1/run0", en, count_reset, running); end
    @(negedge clk);
    total++; if (update_done !== 1'b0 || en !== 1'b0 || cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL sp_idle got=ud%0h/en%0h/rdy%0h exp=ud0/en0/rdy1", update_done, en, cif.cfg_ready); end
  endtask

  task automatic test_rst_pend;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive_cfg(16'd8, 8'd0, 16'd6, 1'b0, 1'b0);
    @(negedge clk);
    cif.cfg_valid = 1'b0;
    total++; if (cif.cfg_ready !== 1'b0) begin bad++; $display("FAIL rp_pend_ready got=%0h exp=0", cif.cfg_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (period !== 16'd0 || compare !== 16'd0 || upnotdown !== 1'b1) begin bad++; $display("FAIL rp_bank got=per%0d/cmp%0d/dir%0h exp=per0/cmp0/dir1", period, compare, upnotdown); end
    total++; if (update_done !== 1'b0) begin bad++; $display("FAIL rp_update_done got=%0h exp=0", update_done); end
    total++; if (en !== 1'b0 || running !== 1'b0 || count_reset !== 1'b0) begin bad++; $display("FAIL rp_ctrl got=en%0h/run%0h/crst%0h exp=0/0/0", en, running, count_reset); end
    @(negedge clk);
    total++; if (update_done !== 1'b0 || period !== 16'd0 || cif.cfg_ready !== 1'b1) begin bad++; $display("FAIL rp_after got=ud%0h/per%0d/rdy%0h exp=ud0/per0/rdy1", update_done, period, cif.cfg_ready); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_idle_cfg();
    test_start();
    test_deferred();
    test_immediate();
    test_zero_period();
    test_stop_pend();
    test_rst_pend();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
